tqvp_reg_arbiter: RTL and testbench

TQVP_REG_ARBITER -- requirements
Module: tqvp_reg_arbiter

---
 rtl/tqvp_reg_arbiter_pkg.sv | 25 ++
 rtl/tqvp_reg_arbiter_if.sv | 13 +
 rtl/tqvp_reg_arbiter_rr_pick2.sv | 14 +
 rtl/tqvp_reg_arbiter.sv | 120 ++++++++++++
 tb/tb_tqvp_reg_arbiter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/tqvp_reg_arbiter_pkg.sv
// Shared types and constants for the two-master register-bus arbiter.
// Holds the FSM state enum, the bus width codes and the read-data mask helper.
package tqvp_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  localparam logic [1:0]  TXN_NONE = 2'b11;
  localparam logic [1:0]  TXN_BYTE = 2'b00;
  localparam logic [1:0]  TXN_HALF = 2'b01;
  localparam logic [1:0]  TXN_WORD = 2'b10;
  localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

  function automatic logic [31:0] mask_width(input logic [31:0] d, input logic [1:0] w);
    logic [31:0] r;
    r = d;
    if (w == TXN_BYTE)      r = {24'd0, d[7:0]};
    else if (w == TXN_HALF) r = {16'd0, d[15:0]};
    return r;
  endfunction

endpackage

// File: rtl/tqvp_reg_arbiter_if.sv
// Per-master register request port: request fields toward the arbiter,
// completion pulse and read data back to the master.
interface tqvp_reg_arbiter_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  write_n;
  logic [1:0]  read_n;
  logic        ack;
  logic [31:0] data_out;

  modport master (output address, data_in, write_n, read_n, input ack, data_out);
  modport slave  (input address, data_in, write_n, read_n, output ack, data_out);
endinterface

// File: rtl/tqvp_reg_arbiter_rr_pick2.sv
// Two-requester round-robin pick: prio names the requester that wins a tie.
module tqvp_rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       gnt,
  output logic       any
);
  always_comb begin
    any = |req;
    gnt = 1'b0;
    if (req == 2'b11) gnt = prio;
    else if (req[1])  gnt = 1'b1;
  end
endmodule

// File: rtl/tqvp_reg_arbiter.sv
// Two-master round-robin arbiter onto a single peripheral register bus.
// Optional read timeout is compiled in with macro TQVP_ARB_TIMEOUT_EN.
module tqvp_reg_arbiter
  import tqvp_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tqvp_reg_arbiter_if.slave     m0,
  tqvp_reg_arbiter_if.slave     m1,
  output logic [5:0]            address,
  output logic [31:0]           data_in,
  output logic [1:0]            data_write_n,
  output logic [1:0]            data_read_n,
  input  logic [31:0]           data_out,
  input  logic                  data_ready,
  output logic                  timeout_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic [1:0]  req;
  logic        gnt, req_any, prio_q, sel_q;
  logic [1:0]  gnt_wr_n, gnt_rd_n, gnt_width, width_q;
  logic        gnt_is_wr;
  logic [5:0]  addr_q;
  logic [31:0] wdata_q, hold0_q, hold1_q, rdata;
  logic        tmo, rd_done, done;

  assign req[0] = (m0.write_n != TXN_NONE) || (m0.read_n != TXN_NONE);
  assign req[1] = (m1.write_n != TXN_NONE) || (m1.read_n != TXN_NONE);

  tqvp_rr_pick2 u_pick (.req(req), .prio(prio_q), .gnt(gnt), .any(req_any));

  // A request with both strobes active is resolved as a write.
  assign gnt_wr_n  = gnt ? m1.write_n : m0.write_n;
  assign gnt_rd_n  = gnt ? m1.read_n  : m0.read_n;
  assign gnt_is_wr = (gnt_wr_n != TXN_NONE);
  assign gnt_width = gnt_is_wr ? gnt_wr_n : gnt_rd_n;

  assign rd_done = (state_q == S_RD) && (data_ready || tmo);
  assign done    = (state_q == S_WR) || rd_done;
  assign rdata   = tmo ? TIMEOUT_DATA : mask_width(data_out, width_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_any) state_d = gnt_is_wr ? S_WR : S_RD;
      S_WR:    state_d = S_IDLE;
      S_RD:    if (rd_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q  <= 1'b0;
      sel_q   <= 1'b0;
      width_q <= TXN_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      if (state_q == S_IDLE && req_any) begin
        prio_q  <= ~gnt;
        sel_q   <= gnt;
        width_q <= gnt_width;
        addr_q  <= gnt ? m1.address : m0.address;
        wdata_q <= gnt ? m1.data_in : m0.data_in;
      end
      if (rd_done && !sel_q) hold0_q <= rdata;
      if (rd_done &&  sel_q) hold1_q <= rdata;
    end
  end

  always_comb begin
    address      = addr_q;
    data_in      = wdata_q;
    data_write_n = (state_q == S_WR) ? width_q : TXN_NONE;
    data_read_n  = (state_q == S_RD) ? width_q : TXN_NONE;
    m0.ack       = done && !sel_q;
    m1.ack       = done &&  sel_q;
    m0.data_out  = (rd_done && !sel_q) ? rdata : hold0_q;
    m1.data_out  = (rd_done &&  sel_q) ? rdata : hold1_q;
  end

`ifdef TQVP_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_err_q;

  // Counts completed RD cycles; the last allowed cycle forces completion.
  assign tmo = (state_q == S_RD) && !data_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = tmo_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == S_RD && !rd_done) ? cnt_q + 1'b1 : '0;
      if (tmo) tmo_err_q <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_tqvp_reg_arbiter.sv
// Directed self-checking bench for tqvp_reg_arbiter (TIMEOUT_CYCLES=4).
module tb_tqvp_reg_arbiter;
  import tqvp_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n, data_read_n;
  logic [31:0] data_out = '0;
  logic        data_ready = 1'b0;
  logic        timeout_err;
  int          n_checks = 0;
  int          n_fail = 0;

  tqvp_reg_arbiter_if m0_if ();
  tqvp_reg_arbiter_if m1_if ();

  tqvp_reg_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0_if.slave), .m1(m1_if.slave),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle_m0();
    m0_if.write_n = TXN_NONE; m0_if.read_n = TXN_NONE;
  endtask
  task automatic idle_m1();
    m1_if.write_n = TXN_NONE; m1_if.read_n = TXN_NONE;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_n"}, 32'(data_write_n), 32'(TXN_NONE));
    check({tag, "_rd_n"}, 32'(data_read_n), 32'(TXN_NONE));
    check({tag, "_addr"}, 32'(address), 32'h0);
    check({tag, "_din"}, data_in, 32'h0);
    check({tag, "_acks"}, {30'd0, m1_if.ack, m0_if.ack}, 32'h0);
    check({tag, "_m0_dout"}, m0_if.data_out, 32'h0);
    check({tag, "_m1_dout"}, m1_if.data_out, 32'h0);
    check({tag, "_tmo_err"}, 32'(timeout_err), 32'h0);
  endtask

  // Expected {m1_ack, m0_ack} per cycle with both masters writing continuously.
  logic [1:0] rr_exp [7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

  initial begin
    idle_m0(); idle_m1();
    m0_if.address = '0; m0_if.data_in = '0;
    m1_if.address = '0; m1_if.data_in = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    // Word write from m0.
    m0_if.address = 6'h04; m0_if.data_in = 32'h1234_5678; m0_if.write_n = TXN_WORD;
    cyc();
    check("wr_wr_n", 32'(data_write_n), 32'(TXN_WORD));
    check("wr_rd_n", 32'(data_read_n), 32'(TXN_NONE));
    check("wr_addr", 32'(address), 32'h04);
    check("wr_din", data_in, 32'h1234_5678);
    check("wr_m0_ack", 32'(m0_if.ack), 32'h1);
    check("wr_m1_ack", 32'(m1_if.ack), 32'h0);
    idle_m0();
    cyc();
    check("wr_one_cycle", 32'(data_write_n), 32'(TXN_NONE));
    check("wr_ack_drop", 32'(m0_if.ack), 32'h0);

    // Byte read from m1, data_ready three cycles late.
    m1_if.address = 6'h08; m1_if.read_n = TXN_BYTE;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rdb_rd_n_wait", 32'(data_read_n), 32'(TXN_BYTE));
      check("rdb_ack_wait", 32'(m1_if.ack), 32'h0);
      m1_if.address = 6'h3F;
    end
    check("rdb_addr_stable", 32'(address), 32'h08);
    cyc();
    data_out = 32'hAABB_CCDD; data_ready = 1'b1; #1;
    check("rdb_m1_ack", 32'(m1_if.ack), 32'h1);
    check("rdb_m1_dout", m1_if.data_out, 32'h0000_00DD);
    check("rdb_m0_hold", m0_if.data_out, 32'h0);
    check("rdb_m0_ack", 32'(m0_if.ack), 32'h0);
    idle_m1();
    cyc();
    data_ready = 1'b0;
    check("rdb_idle", 32'(data_read_n), 32'(TXN_NONE));
    check("rdb_dout_hold", m1_if.data_out, 32'h0000_00DD);

    // Half read from m0 with data already ready.
    m0_if.address = 6'h10; m0_if.read_n = TXN_HALF;
    data_out = 32'hAABB_CCDD; data_ready = 1'b1;
    cyc();
    check("rdh_m0_ack", 32'(m0_if.ack), 32'h1);
    check("rdh_m0_dout", m0_if.data_out, 32'h0000_CCDD);
    check("rdh_m1_hold", m1_if.data_out, 32'h0000_00DD);
    idle_m0();
    cyc();
    data_ready = 1'b0;

    // Round-robin: fresh reset so m0 leads, both write continuously.
    rst_n = 1'b0; #2; rst_n = 1'b1;
    m0_if.data_in = 32'hA0A0_A0A0; m0_if.write_n = TXN_WORD; m0_if.address = 6'h01;
    m1_if.data_in = 32'hB1B1_B1B1; m1_if.write_n = TXN_HALF; m1_if.address = 6'h02;
    for (int i = 0; i < 7; i++) begin
      cyc();
      check($sformatf("rr_acks_%0d", i), {30'd0, m1_if.ack, m0_if.ack}, 32'(rr_exp[i]));
      if (rr_exp[i] == 2'b01) check($sformatf("rr_din_%0d", i), data_in, 32'hA0A0_A0A0);
      if (rr_exp[i] == 2'b10) check($sformatf("rr_wr_n_%0d", i), 32'(data_write_n), 32'(TXN_HALF));
      if (rr_exp[i] == 2'b00) check($sformatf("rr_idle_%0d", i), 32'(data_write_n), 32'(TXN_NONE));
    end
    idle_m0(); idle_m1();
    cyc(); cyc();

    // Write and read strobes together resolve to a write.
    m0_if.address = 6'h05; m0_if.data_in = 32'hCAFE_0001;
    m0_if.write_n = TXN_WORD; m0_if.read_n = TXN_HALF;
    cyc();
    check("both_wr_n", 32'(data_write_n), 32'(TXN_WORD));
    check("both_rd_n", 32'(data_read_n), 32'(TXN_NONE));
    check("both_ack", 32'(m0_if.ack), 32'h1);
    idle_m0();
    cyc();
    check("both_rd_n_after", 32'(data_read_n), 32'(TXN_NONE));

    // Reset during a read aborts it with no ack.
    m1_if.address = 6'h2A; m1_if.read_n = TXN_WORD;
    cyc();
    check("rst_rd_active", 32'(data_read_n), 32'(TXN_WORD));
    rst_n = 1'b0; #1;
    check_reset_outputs("midrst");
    cyc();
    check("midrst_no_ack", {30'd0, m1_if.ack, m0_if.ack}, 32'h0);
    idle_m1();
    @(negedge clk); rst_n = 1'b1;
    m0_if.address = 6'h3F; m0_if.data_in = 32'h0BAD_F00D; m0_if.write_n = TXN_BYTE;
    cyc();
    check("post_rst_wr_n", 32'(data_write_n), 32'(TXN_BYTE));
    check("post_rst_addr", 32'(address), 32'h3F);
    check("post_rst_ack", 32'(m0_if.ack), 32'h1);
    idle_m0();
    cyc();

    // Read that never sees data_ready.
    data_ready = 1'b0;
    m1_if.address = 6'h11; m1_if.read_n = TXN_WORD;
`ifdef TQVP_ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("tmo_wait_%0d", i), 32'(m1_if.ack), 32'h0);
    end
    cyc();
    check("tmo_ack", 32'(m1_if.ack), 32'h1);
    check("tmo_dout", m1_if.data_out, 32'hFFFF_FFFF);
    idle_m1();
    cyc(); cyc();
    check("tmo_err_sticky", 32'(timeout_err), 32'h1);
    rst_n = 1'b0; #1;
    check("tmo_err_reset", 32'(timeout_err), 32'h0);
    @(negedge clk); rst_n = 1'b1;
`else
    for (int i = 0; i < 8; i++) begin
      cyc();
      check($sformatf("nowait_ack_%0d", i), 32'(m1_if.ack), 32'h0);
    end
    check("nowait_rd_n", 32'(data_read_n), 32'(TXN_WORD));
    check("nowait_tmo_err", 32'(timeout_err), 32'h0);
    data_out = 32'h1357_9BDF; data_ready = 1'b1; #1;
    check("late_ack", 32'(m1_if.ack), 32'h1);
    check("late_dout", m1_if.data_out, 32'h1357_9BDF);
    idle_m1();
    cyc();
    data_ready = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
